// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types and constants for the drive command sequencer
package motor_pkg;

  localparam logic [6:0] ACC_MAX = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    TRIP  = 2'd2,
    ESTOP = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [6:0] acc;
    logic [7:0] ste;
    logic       brk;
  } motor_cmd_t;

endpackage

// File: rtl/motor_cmd_ctrl_if.sv
// rtl/motor_cmd_ctrl_if.sv - one drive command channel (valid/ready plus payload)
interface motor_cmd_ctrl_if;
  import motor_pkg::*;

  logic       valid;
  logic       ready;
  motor_cmd_t cmd;

  modport master (output valid, output cmd, input ready);
  modport slave  (input valid, input cmd, output ready);

endinterface

// File: rtl/motor_cmd_ctrl_acc_ramp.sv
// rtl/motor_cmd_ctrl_acc_ramp.sv - acceleration slew limiter, built only with MOTOR_CTRL_RAMP_EN
`ifdef MOTOR_CTRL_RAMP_EN
module acc_ramp #(
  parameter int RAMP_DIV = 100_000,
  parameter int ACC_STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] target,
  input  logic       force_zero,
  output logic [6:0] cur_acc
);
  localparam int               DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [7:0]       STEP     = 8'(ACC_STEP);

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [7:0]       cur_w;
  logic [7:0]       tgt_w;
  logic [7:0]       gap;
  logic [7:0]       step;
  logic             up;
  logic [6:0]       next_acc;

  assign tick = (div_q == DIV_LAST);

  // free-running tick divider, only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n || tick) div_q <= '0;
    else                div_q <= div_q + 1'b1;
  end

  // one step toward the target, clipped to the remaining gap so it never overshoots
  always_comb begin
    cur_w    = {1'b0, cur_acc};
    tgt_w    = {1'b0, target};
    up       = (tgt_w >= cur_w);
    gap      = up ? (tgt_w - cur_w) : (cur_w - tgt_w);
    step     = (gap < STEP) ? gap : STEP;
    next_acc = up ? 7'(cur_w + step) : 7'(cur_w - step);
  end

  // braking drops the output immediately; otherwise move only on ticks
  always_ff @(posedge clk) begin
    if (!rst_n || force_zero) cur_acc <= '0;
    else if (tick)            cur_acc <= next_acc;
  end

endmodule
`endif

// File: rtl/motor_cmd_ctrl.sv
// rtl/motor_cmd_ctrl.sv - drive command sequencer top, MOTOR_CTRL_RAMP_EN enables acc slew limiting
module motor_cmd_ctrl
  import motor_pkg::*;
#(
  parameter int WDT_CYCLES = 5_000_000,
  parameter int RAMP_DIV   = 100_000,
  parameter int ACC_STEP   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  motor_cmd_ctrl_if.slave pl,
  motor_cmd_ctrl_if.slave rc,
  input  logic            estop,
  output logic [6:0]      out_acc,
  output logic [7:0]      out_ste,
  output logic            out_brk,
  output logic            src_rc,
  output logic            wdt_trip,
  output logic [1:0]      state
);
  localparam int               WDT_W    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  if (WDT_CYCLES < 2 || RAMP_DIV < 1 || ACC_STEP < 1 || ACC_STEP > int'(ACC_MAX)) begin : g_bad_param
    $error("motor_cmd_ctrl: parameter out of range");
  end

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic             rc_take;
  logic             pl_take;
  logic             take;
  motor_cmd_t       cmd;
  logic [WDT_W-1:0] wdt_q;
  logic [6:0]       target_q;

  // remote has priority; planner is held off whenever remote is requesting
  assign rc.ready = rst_n & ~estop;
  assign pl.ready = rst_n & ~estop & ~rc.valid;
  assign rc_take  = rc.valid & rc.ready;
  assign pl_take  = pl.valid & pl.ready;
  assign take     = rc_take | pl_take;
  assign cmd      = rc_take ? rc.cmd : pl.cmd;

  assign state    = state_q;
  assign wdt_trip = (state_q == TRIP);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: estop overrides everything, an accept in RUN beats the watchdog
  always_comb begin
    state_d = state_q;
    if (estop) begin
      state_d = ESTOP;
    end else begin
      case (state_q)
        IDLE, TRIP: if (take) state_d = RUN;
        RUN:        if (!take && wdt_q == WDT_LAST) state_d = TRIP;
        ESTOP:      state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // watchdog counts quiet cycles in RUN and saturates at the trip value
  always_ff @(posedge clk) begin
    if (!rst_n || take || state_q != RUN) wdt_q <= '0;
    else if (wdt_q != WDT_LAST)           wdt_q <= wdt_q + 1'b1;
  end

  // command registers; anything but RUN forces a braked, zero-target command
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ste  <= '0;
      out_brk  <= 1'b1;
      src_rc   <= 1'b0;
      target_q <= '0;
    end else if (state_d != RUN) begin
      out_brk  <= 1'b1;
      target_q <= '0;
    end else if (take) begin
      src_rc <= rc_take;
      if (cmd.brk) begin
        out_brk  <= 1'b1;
        target_q <= '0;
      end else begin
        out_brk  <= 1'b0;
        out_ste  <= cmd.ste;
        target_q <= cmd.acc;
      end
    end
  end

`ifdef MOTOR_CTRL_RAMP_EN
  logic force_zero;
  assign force_zero = (state_d != RUN) | (take & cmd.brk);

  acc_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .ACC_STEP (ACC_STEP)
  ) u_acc_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .target     (target_q),
    .force_zero (force_zero),
    .cur_acc    (out_acc)
  );
`else
  assign out_acc = target_q;
`endif

endmodule

// File: doc/motor_cmd_ctrl.md
# motor_cmd_ctrl

Command sequencer in front of the differential-drive mixer. Arbitrates drive commands (acceleration, signed steering, brake) from the autonomous planner and the remote/manual link, and slew-limits acceleration. Enforces a command watchdog and an emergency stop, then presents one registered command set to the mixer's acc/ste/brk inputs. Sits between the control interfaces and the motor mixer/PWM stage.

## Interface
Parameters:
- WDT_CYCLES, 5_000_000: cycles without an accepted command before a watchdog trip (50 ms at 100 MHz).
- RAMP_DIV, 100_000: cycles between acceleration ramp steps.
- ACC_STEP, 1: maximum change of out_acc per ramp step (1..127).

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- pl_valid / pl_ready  in / out  1 / 1  planner command handshake.
- pl_acc, pl_ste, pl_brk  in  7, 8, 1  planner acceleration (unsigned), steering (two's complement, positive = left), brake.
- rc_valid / rc_ready  in / out  1 / 1  remote command handshake.
- rc_acc, rc_ste, rc_brk  in  7, 8, 1  remote command, same encoding as the planner command.
- estop  in  1  level emergency stop, synchronous to clk.
- out_acc, out_ste, out_brk  out  7, 8, 1  registered command to the mixer.
- src_rc  out  1  source of the last accepted command: 1 = remote.
- wdt_trip  out  1  watchdog tripped.
- state  out  2  FSM state.

## Operation
- FSM states: IDLE=0, RUN=1, TRIP=2, ESTOP=3.
- Handshake (combinational):
  - rc_ready = rst_n & !estop.
  - pl_ready = rst_n & !estop & !rc_valid.
  - A command is accepted when valid & ready; remote wins on simultaneous valid.
  - An unaccepted requester holds its payload until accepted.
- Transitions:
  - IDLE→RUN on any accepted command.
  - RUN→TRIP when the watchdog count reaches WDT_CYCLES-1.
  - TRIP→RUN on an accepted command.
  - Any state→ESTOP while estop=1.
  - ESTOP→IDLE on the first cycle estop=0.
- Watchdog counter:
  - Cleared on every accept and in IDLE, TRIP and ESTOP.
  - Increments only in RUN.
  - Saturates; never wraps.
- In IDLE, TRIP and ESTOP: out_acc=0, out_brk=1, ramp target=0. out_ste holds its last value (0 after reset).
- wdt_trip=1 only in TRIP.
- Accepted command with brk=1:
  - out_brk=1, out_acc=0 and target=0 at the next edge; no ramp.
  - State stays RUN.
- Accepted command with brk=0:
  - out_brk=0 and out_ste=cmd ste at the next edge.
  - Target becomes cmd acc.
- Ramp: on each tick, out_acc moves toward the target by min(ACC_STEP, |target-out_acc|). This applies to both acceleration and deceleration. Arithmetic is in 8 bits, with no overshoot and no wrap outside 0..127.
- Ramp tick: a free-running counter 0..RAMP_DIV-1, cleared by reset. A tick is asserted when the counter equals RAMP_DIV-1.
- A new target mid-ramp takes effect from the next tick; out_acc is not reset.

## Timing
- Reset values:
  - out_acc=0, out_ste=0, out_brk=1.
  - src_rc=0, wdt_trip=0, state=IDLE.
  - Watchdog and tick counters = 0.
  - pl_ready=rc_ready=0 while rst_n=0.
- Accept at edge N → out_ste, out_brk, src_rc, state valid after N+1.
- With MOTOR_CTRL_RAMP_EN: first out_acc change at the first tick after N+1.
- estop rising → ESTOP and braked outputs at the next edge. Readies drop combinationally in the same cycle.
- Watchdog: with no accepts after entering RUN at edge N, TRIP at edge N+WDT_CYCLES.
- rst_n low mid-ramp or in any state → reset values at the next edge; the in-flight command is dropped.

## Configuration
- MOTOR_CTRL_RAMP_EN defined: slew limiting as above.
- MOTOR_CTRL_RAMP_EN undefined:
  - out_acc = accepted acc at N+1.
  - The tick counter and RAMP_DIV/ACC_STEP logic are not synthesized; the parameters remain in the interface, unused.
  - Brake, watchdog and estop behaviour are unchanged.

## Structure
- Package motor_pkg:
  - motor_cmd_t struct {acc[6:0], ste[7:0], brk}.
  - Enum ctrl_state_e {IDLE, RUN, TRIP, ESTOP}.
  - ACC_MAX=7'h7F.
- Sub-module acc_ramp: tick counter plus step logic.
  - Inputs: target, force_zero.
  - Output: cur_acc.
  - Instantiated only under MOTOR_CTRL_RAMP_EN.

## Test plan
Bench parameters: WDT_CYCLES=32, RAMP_DIV=4, ACC_STEP=10.
- Reset held 3 cycles → out_acc=0, out_ste=0, out_brk=1, state=0, both readies 0.
- Planner cmd acc=100, ste=0, brk=0.
  - Ramp on: state=1 at N+1; out_acc steps 10,20,…,100 every 4 cycles, then holds.
  - Ramp off: out_acc=100 at N+1.
- rc (acc=20, ste=8'hE2) and pl (acc=90) valid in the same cycle → rc accepted, pl_ready=0, src_rc=1, out_ste=8'hE2. pl is accepted the cycle after rc_valid drops.
- Brake cmd while out_acc=60 → out_acc=0, out_brk=1 at N+1, state stays RUN.
- RUN with no accepts for 32 cycles → state=2, wdt_trip=1, out_acc=0, out_brk=1. Next accepted cmd → state=1, wdt_trip=0.
- estop=1 mid-ramp at out_acc=40 → readies 0 same cycle; state=3, out_acc=0 next edge. Release → state=0, outputs stay braked until a new cmd.
